press_decoder: RTL and testbench
================================

# press_decoder

Classifies press gestures on a synchronous, active-high "button held" level into one-cycle `single`, `double` and `long` event strobes. It sits downstream of the button pulse indicator, on the same clock. It turns that module's held level back into discrete user commands for the control logic. Exactly one event is produced per gesture, and no phantom event is produced after reset.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold length that qualifies as a long press (1 s at 50 MHz); must be ≥ 2.
- `GAP_CYCLES`, default 12_500_000: maximum released gap between the two presses of a double press (250 ms); must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `press`  in  1  button-held level, 1 while pressed; synchronous to `clk`.
- `single`  out  1  one-cycle strobe: single short press completed.
- `double`  out  1  one-cycle strobe: double short press completed.
- `long`  out  1  one-cycle strobe: press held for the long threshold.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- One counter, width `$clog2(max(LONG_CYCLES, GAP_CYCLES))`; it never wraps, because it is cleared on every state entry.
- FSM states:
  - **RELEASE** (reset state): stay while `press`=1. Go to IDLE on `press`=0. Emits nothing.
  - **IDLE**: on `press`=1, go to HELD1 with cnt=0.
  - **HELD1**:
    - `press`=0: go to WAIT_GAP with cnt=0.
    - Else if cnt==LONG_CYCLES-1: set `long` for one cycle and go to RELEASE.
    - Else: cnt++.
  - **WAIT_GAP**:
    - `press`=1: go to HELD2.
    - Else if cnt==GAP_CYCLES-1: set `single` for one cycle and go to IDLE.
    - Else: cnt++.
  - **HELD2**: on `press`=0, set `double` for one cycle and go to IDLE. There is no long detection in HELD2; a second press of any length yields `double`.
- Simultaneous events:
  - In HELD1, release wins over a count reaching its threshold.
  - In WAIT_GAP, a new press wins over the gap expiring.
- `single`, `double` and `long` are registered. They are mutually exclusive and each is high for exactly one cycle.
- `busy` is decoded from the state register, so it is glitch-free.

## Timing
- Reset values while `rst`=0: `single`=`double`=`long`=0, `busy`=1, state=RELEASE, cnt=0. Asynchronous assert, synchronous deassert.
- Reset forces RELEASE, so a button already held at reset release produces no event. `busy` falls the cycle after the first low sample of `press`.
- Reset mid-gesture aborts the gesture silently: no strobe during or after the reset.
- Long press: first high sample at cycle n. If `press` stays high for samples n..n+LONG_CYCLES (LONG_CYCLES+1 samples), `long` is high in cycle n+LONG_CYCLES+1. A release at sample n+LONG_CYCLES gives no `long`; that gesture is treated as a short press.
- Single press: first low sample in HELD1 at cycle m. If samples m+1..m+GAP_CYCLES are all low, `single` is high in cycle m+GAP_CYCLES+1, the same cycle `busy` falls.
- Double press: a high sample at any of m+1..m+GAP_CYCLES enters HELD2. `double` is high in the cycle after the first low sample in HELD2.
- A new press is accepted in the first IDLE cycle after any strobe.

## Test plan
Bench parameters: LONG_CYCLES=8, GAP_CYCLES=4.
- **Reset while held**: hold `rst`=0 with `press`=1, release `rst`, keep `press`=1 for 20 cycles, then drop it.
  - Required: no strobes at all; `busy`=1 throughout, falling exactly 1 cycle after the first low sample.
- **Single press**: `press` high for 3 cycles, then low for 10.
  - Required: `single` high for exactly 1 cycle, 5 cycles after the first low sample; `double` and `long` stay 0.
- **Double press at the gap boundary**, two runs:
  - Press 3, low 4, press 3, low. Required: `double` for 1 cycle, on the cycle after the second release sample; no `single`.
  - Same sequence with low 5. Required: `single` after the first press, then a separate `single` for the second press.
- **Long press at the threshold**, two runs:
  - Hold 9 samples. Required: `long` for 1 cycle at n+9; nothing on release; `busy` falls 1 cycle after release.
  - Hold exactly 8 samples. Required: no `long`, followed by `single`.
- **Mid-gesture reset**: assert `rst`=0 during WAIT_GAP (cnt=2).
  - Required: outputs 0 immediately, no `single` afterwards, `busy`=1 until `press` is sampled low after reset.
- **Back-to-back gestures**: issue a press one cycle after a `single` strobe.
  - Required: the new gesture is decoded normally (HELD1 is entered); no strobe is lost or duplicated.

Source files
------------

// File: rtl/press_decoder.sv
// Classifies presses on a synchronous "button held" level into one-cycle
// single / double / long event strobes, one event per gesture.
module press_decoder #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic single,
  output logic double,
  output logic long,
  output logic busy
);

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    RELEASE  = 3'd0,
    IDLE     = 3'd1,
    HELD1    = 3'd2,
    WAIT_GAP = 3'd3,
    HELD2    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;

  // The counter is cleared on every state change, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      RELEASE: begin
        if (!press) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (press) begin
          state_d = HELD1;
          cnt_d   = '0;
        end
      end
      HELD1: begin
        if (!press) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_GAP: begin
        if (press) begin
          state_d = HELD2;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD2: begin
        // Second press of any length is a double; no long detection here.
        if (!press) begin
          double_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RELEASE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

  assign single = single_q;
  assign double = double_q;
  assign long   = long_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder: directed gesture scenarios plus random press runs,
// checked every cycle against a run-length model of the gesture rules.
module tb_press_decoder;

  localparam int LONG_CYCLES = 8;
  localparam int GAP_CYCLES  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic press = 1'b0;
  logic sgl, dbl, lng, bsy;

  press_decoder #(.LONG_CYCLES(LONG_CYCLES), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .press(press),
    .single(sgl), .double(dbl), .long(lng), .busy(bsy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Gesture model: armed = a low was seen since reset/long; presses counts
  // presses in the current gesture; hi_len/lo_len are current run lengths.
  bit m_armed;
  int m_presses;
  bit m_in_gap;
  int m_hi_len;
  int m_lo_len;
  logic [3:0] exp_v;  // {single, double, long, busy}
  logic [3:0] obs_v;

  task automatic model_reset();
    m_armed = 0; m_presses = 0; m_in_gap = 0; m_hi_len = 0; m_lo_len = 0;
    exp_v = 4'b0001;
  endtask

  task automatic model_step(input logic s);
    logic es, ed, el;
    es = 0; ed = 0; el = 0;
    if (!m_armed) begin
      if (!s) m_armed = 1;
    end else if (m_presses == 0) begin
      if (s) begin m_presses = 1; m_in_gap = 0; m_hi_len = 1; end
    end else if (m_presses == 1 && !m_in_gap) begin
      if (s) begin
        m_hi_len++;
        if (m_hi_len == LONG_CYCLES + 1) begin el = 1; m_armed = 0; m_presses = 0; end
      end else begin
        m_in_gap = 1; m_lo_len = 1;
      end
    end else if (m_presses == 1) begin
      if (s) m_presses = 2;
      else begin
        m_lo_len++;
        if (m_lo_len == GAP_CYCLES + 1) begin es = 1; m_presses = 0; end
      end
    end else begin
      if (!s) begin ed = 1; m_presses = 0; end
    end
    exp_v = {es, ed, el, !(m_armed && m_presses == 0)};
  endtask

  // Drive one press sample, let the DUT take it, then observe on the falling edge.
  task automatic step(input logic p);
    press = p;
    @(posedge clk);
    model_step(p);
    @(negedge clk);
    obs_v = {sgl, dbl, lng, bsy};
  endtask

  task automatic test_reset();
    int strobes;
    strobes = 0;
    rst = 1'b0; press = 1'b1; model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({sgl, dbl, lng, bsy} !== 4'b0001) $display("FAIL reset_values: got %b want 0001", {sgl, dbl, lng, bsy});
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      strobes += obs_v[3] + obs_v[2] + obs_v[1];
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL reset_held[%0d]: got %b want %b", i, obs_v, exp_v);
      else n_pass++;
    end
    step(1'b0);
    n_checks++;
    if (obs_v !== 4'b0000) $display("FAIL reset_busy_fall: got %b want 0000", obs_v);
    else n_pass++;
    n_checks++;
    if (strobes != 0) $display("FAIL reset_no_strobe: got %0d strobes want 0", strobes);
    else n_pass++;
  endtask

  task automatic test_single();
    int idx;
    idx = -1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL single_hi[%0d]: got %b want %b", i, obs_v, exp_v);
      else n_pass++;
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      if (obs_v[3]) idx = (idx == -1) ? k : 99;
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL single_lo[%0d]: got %b want %b", k, obs_v, exp_v);
      else n_pass++;
    end
    // Strobe in the cycle after low sample k=4, i.e. 5 cycles after the first low sample.
    n_checks++;
    if (idx != 4) $display("FAIL single_timing: got low index %0d want 4", idx);
    else n_pass++;
  endtask

  task automatic test_double_gap(input int gap_low);
    int n_s, n_d, n_l;
    n_s = 0; n_d = 0; n_l = 0;
    for (int ph = 0; ph < 4; ph++) begin
      int len;
      logic lvl;
      lvl = (ph % 2 == 0);
      len = (ph == 0 || ph == 2) ? 3 : (ph == 1 ? gap_low : 8);
      for (int i = 0; i < len; i++) begin
        step(lvl);
        n_s += obs_v[3]; n_d += obs_v[2]; n_l += obs_v[1];
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL double_gap%0d[%0d.%0d]: got %b want %b", gap_low, ph, i, obs_v, exp_v);
        else n_pass++;
      end
    end
    n_checks++;
    if (gap_low <= GAP_CYCLES) begin
      if ({n_s, n_d, n_l} !== {32'd0, 32'd1, 32'd0})
        $display("FAIL double_gap%0d_count: got s=%0d d=%0d l=%0d want s=0 d=1 l=0", gap_low, n_s, n_d, n_l);
      else n_pass++;
    end else begin
      if ({n_s, n_d, n_l} !== {32'd2, 32'd0, 32'd0})
        $display("FAIL double_gap%0d_count: got s=%0d d=%0d l=%0d want s=2 d=0 l=0", gap_low, n_s, n_d, n_l);
      else n_pass++;
    end
  endtask

  task automatic test_long(input int hold);
    int n_s, n_l, l_idx;
    n_s = 0; n_l = 0; l_idx = -1;
    for (int i = 0; i < hold; i++) begin
      step(1'b1);
      if (obs_v[1]) begin n_l++; l_idx = i; end
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL long%0d_hi[%0d]: got %b want %b", hold, i, obs_v, exp_v);
      else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      n_s += obs_v[3]; n_l += obs_v[1];
      if (k == 0 && hold > LONG_CYCLES) begin
        n_checks++;
        if (obs_v !== 4'b0000) $display("FAIL long%0d_release: got %b want 0000", hold, obs_v);
        else n_pass++;
      end
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL long%0d_lo[%0d]: got %b want %b", hold, k, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (hold > LONG_CYCLES) begin
      if (n_l != 1 || l_idx != LONG_CYCLES || n_s != 0)
        $display("FAIL long%0d_event: got long=%0d at %0d single=%0d want long=1 at %0d single=0", hold, n_l, l_idx, n_s, LONG_CYCLES);
      else n_pass++;
    end else begin
      if (n_l != 0 || n_s != 1)
        $display("FAIL long%0d_event: got long=%0d single=%0d want long=0 single=1", hold, n_l, n_s);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int n_str;
    n_str = 0;
    repeat (3) step(1'b1);
    repeat (3) step(1'b0);   // now in the gap with cnt=2
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({sgl, dbl, lng, bsy} !== 4'b0001) $display("FAIL midrst_immediate: got %b want 0001", {sgl, dbl, lng, bsy});
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({sgl, dbl, lng, bsy} !== 4'b0001) $display("FAIL midrst_held: got %b want 0001", {sgl, dbl, lng, bsy});
    else n_pass++;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      n_str += obs_v[3] + obs_v[2] + obs_v[1];
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL midrst_after[%0d]: got %b want %b", k, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (n_str != 0) $display("FAIL midrst_no_strobe: got %0d strobes want 0", n_str);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_s;
    bit seen;
    n_s = 0; seen = 0;
    repeat (3) step(1'b1);
    for (int k = 0; k < 10 && !seen; k++) begin
      step(1'b0);
      if (obs_v[3]) begin seen = 1; n_s++; end
    end
    n_checks++;
    if (!seen) $display("FAIL b2b_first_single: got none within 10 cycles want 1");
    else n_pass++;
    step(1'b1);   // driven during the strobe cycle
    n_checks++;
    if (obs_v !== 4'b0001 || exp_v !== 4'b0001) $display("FAIL b2b_held1: got %b want 0001", obs_v);
    else n_pass++;
    step(1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      n_s += obs_v[3];
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL b2b_lo[%0d]: got %b want %b", k, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (n_s != 2) $display("FAIL b2b_count: got %0d singles want 2", n_s);
    else n_pass++;
  endtask

  task automatic test_random();
    logic lvl;
    lvl = 1'b1;
    for (int r = 0; r < 60; r++) begin
      int len;
      len = $urandom_range(1, 11);
      for (int i = 0; i < len; i++) begin
        step(lvl);
        n_checks++;
        if (obs_v !== exp_v) $display("FAIL random[%0d.%0d]: got %b want %b", r, i, obs_v, exp_v);
        else n_pass++;
      end
      lvl = ~lvl;
    end
  endtask

  initial begin
    test_reset();
    repeat (6) step(1'b0);
    test_single();
    test_double_gap(GAP_CYCLES);
    test_double_gap(GAP_CYCLES + 1);
    test_long(LONG_CYCLES + 1);
    test_long(LONG_CYCLES);
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
